wbcarbiter: RTL and testbench
=============================

# wbcarbiter

Round-robin Wishbone arbiter that lets NM bus masters share the single master port of the wbcrouter crossbar. It forwards the owning master's signals to the router, routes ack/err back only to the owner, and aborts with a bus error when a slave stalls past TIMEOUT cycles. The owning master holds the grant for the whole duration of its CYC.

## Interface
- NM, 4: number of requesting masters (≥2)
- AW, 32: address width
- DW, 32: data width
- SW, DW/8: byte-select width
- TIMEOUT, 255: stall limit in cycles; 0 disables the watchdog
- TW, 8: watchdog counter width; TIMEOUT < 2^TW

Ports:
- i_clk  in  1  clock; everything is clocked on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_mcyc  in  NM  per-master CYC
- i_mstb  in  NM  per-master STB
- i_mwe  in  NM  per-master WE
- i_maddr  in  NM*AW  per-master address, master m at [m*AW +: AW]
- i_mdata  in  NM*DW  per-master write data
- i_msel  in  NM*SW  per-master byte select
- o_mack  out  NM  ack, asserted to the owner only
- o_mdata  out  DW  read data, i_sdata broadcast to all masters
- o_merr  out  NM  error, asserted to the owner only
- o_scyc, o_sstb, o_swe  out  1 each  to router
- o_saddr  out  AW; o_sdata  out  DW; o_ssel  out  SW  to router
- i_sack  in  1; i_sdata  in  DW; i_serr  in  1  from router
- o_grant  out  NM  one-hot owner, all-zero when no master owns the bus
- o_busy  out  1  high in BUSY or ABORT

## Operation
- State machine states: IDLE, BUSY, ABORT. Registers: state, owner index, last-granted index `last`, watchdog counter.
- IDLE:
  - o_scyc, o_sstb, o_swe = 0; o_saddr, o_sdata, o_ssel = 0; o_mack and o_merr all 0.
  - If any i_mcyc is high: select the first master with i_mcyc high, searching (last+1) mod NM upward with wrap. Latch it as owner, set last = owner, go to BUSY, clear the counter.
- BUSY:
  - o_scyc = i_mcyc[owner]; o_sstb = i_mstb[owner]; o_swe = i_mwe[owner]; addr/data/sel are the owner's slices.
  - o_mack[owner] = i_sack and o_merr[owner] = i_serr, combinational. All other bits are 0.
  - Release: if i_mcyc[owner] = 0, the next state is IDLE. Requests from other masters are not examined in the release cycle.
  - Watchdog, when TIMEOUT ≠ 0:
    - If i_mstb[owner] & !i_sack & !i_serr, counter +1; otherwise counter clears.
    - If the counter reaches TIMEOUT at the clock edge, go to ABORT.
    - An ack or err in the cycle that would reach TIMEOUT wins: counter clears and the state stays BUSY.
  - The counter saturates and never wraps.
- ABORT:
  - o_scyc = o_sstb = 0; slave responses are ignored.
  - o_merr[owner] = 1 in the first ABORT cycle only.
  - Stays in ABORT until i_mcyc[owner] = 0, then goes to IDLE. If cyc is already low in the first ABORT cycle, the err pulse is still given and the next state is IDLE.
- o_mdata = i_sdata at all times.
- o_grant is one-hot of owner in BUSY and ABORT, and 0 in IDLE.
- Slave ack/err arriving in IDLE or ABORT is dropped.
- Reset: state = IDLE, last = NM-1 (master 0 has first priority), owner = 0, counter = 0.
  - All o_* outputs are 0 except o_mdata, which follows i_sdata.
  - Reset mid-transaction: after the reset edge o_scyc = 0 immediately and no ack or err is issued to the former owner.

## Timing
- Grant latency: a request seen in IDLE at edge N gives o_scyc = 1 in the cycle after edge N, i.e. one cycle after i_mcyc rises.
- Ack/err return path is combinational, zero added latency.
- Handover: the owner drops cyc in cycle k → IDLE in k+1 → the next owner is driven in k+2. There is exactly one dead cycle between owners.
- A single master re-requesting back to back gets the same one dead cycle, then the grant again if it is the only requester.
- Watchdog, TIMEOUT = T: stb high from BUSY cycle c with no response → ABORT entered at cycle c+T → o_merr pulse in cycle c+T.

## Test plan
- Single master 0 write, slave acks in the 2nd stb cycle: o_scyc rises one cycle after i_mcyc[0]; o_mack = 0001 for one cycle; o_grant = 0001; one cycle after cyc drops, o_grant = 0000.
- Masters 0, 1 and 3 all requesting continuously from reset, each dropping cyc after one acked transfer: grant order 0→1→3→0, with one idle cycle between owners; master 2 is never granted.
- TIMEOUT = 4, owner 2 strobes with the slave silent: o_merr = 0100 for exactly one cycle, 4 cycles after stb; o_scyc = 0 while cyc is held; the bus returns to IDLE after cyc drops. Repeat with an ack arriving in the 4th cycle: no err, transfer completes.
- Non-owner ack isolation: master 1 owns the bus while master 0 holds cyc/stb; a slave ack produces o_mack = 0010, master 0 sees 0, and o_saddr equals master 1's address.
- Reset mid-transaction, asserted while BUSY with stb high: the cycle after the reset edge has o_scyc = 0, o_grant = 0, no ack or err; with masters 0 and 2 then requesting, the first grant goes to master 0.
- TIMEOUT = 0, slave stalls 1000 cycles: no o_merr; the bus stays BUSY until the ack arrives.

Source files
------------

// File: rtl/wbcarbiter.sv
// Round-robin Wishbone arbiter: NM masters share one router master port.
// The owner keeps the grant for its whole CYC; a watchdog aborts stalled strobes with an error.
module wbcarbiter #(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [DW-1:0]    o_mdata,
    output logic [NM-1:0]    o_merr,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic [DW-1:0]    i_sdata,
    input  logic             i_serr,
    output logic [NM-1:0]    o_grant,
    output logic             o_busy
);

    localparam int OW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last;
    logic [TW-1:0] wdog;
    logic          abort_first;

    logic [OW-1:0] next_owner;
    logic          any_req;
    logic          stall;
    logic [TW-1:0] wdog_inc;

    logic [AW-1:0] m_addr [NM];
    logic [DW-1:0] m_data [NM];
    logic [SW-1:0] m_sel  [NM];

    always_comb begin
        for (int m = 0; m < NM; m++) begin
            m_addr[m] = i_maddr[m*AW +: AW];
            m_data[m] = i_mdata[m*DW +: DW];
            m_sel[m]  = i_msel[m*SW +: SW];
        end
    end

    // Round-robin search starting just after the last granted master, wrapping.
    always_comb begin
        logic [OW-1:0] idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        next_owner = last;
        any_req    = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NM; i++) begin
            idx = OW'((int'(last) + i) % NM);
            if (!any_req && i_mcyc[idx]) begin
                any_req    = 1'b1;
                next_owner = idx;
            end
        end
    end

    assign stall    = i_mstb[owner] & ~i_sack & ~i_serr;
    assign wdog_inc = (wdog == '1) ? wdog : wdog + 1'b1;

    // NOTE: state registers use non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= OW'(NM - 1);
            wdog        <= '0;
            abort_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    abort_first <= 1'b0;
                    wdog        <= '0;
                    if (any_req) begin
                        owner <= next_owner;
                        last  <= next_owner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!i_mcyc[owner]) begin
                        state <= IDLE;
                        wdog  <= '0;
                    end else if (TIMEOUT != 0 && stall) begin
                        if (wdog_inc == TW'(TIMEOUT)) begin
                            state       <= ABORT;
                            abort_first <= 1'b1;
                            wdog        <= '0;
                        end else begin
                            wdog <= wdog_inc;
                        end
                    end else begin
                        // A response (or an idle strobe) always rearms the watchdog.
                        wdog <= '0;
                    end
                end
                ABORT: begin
                    abort_first <= 1'b0;
                    if (!i_mcyc[owner])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forwarding and the ack/err return path are combinational so no latency is added.
    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        o_mack  = '0;
        o_merr  = '0;
        o_grant = '0;
        case (state)
            BUSY: begin
                o_scyc         = i_mcyc[owner];
                o_sstb         = i_mstb[owner];
                o_swe          = i_mwe[owner];
                o_saddr        = m_addr[owner];
                o_sdata        = m_data[owner];
                o_ssel         = m_sel[owner];
                o_mack[owner]  = i_sack;
                o_merr[owner]  = i_serr;
                o_grant[owner] = 1'b1;
            end
            ABORT: begin
                o_merr[owner]  = abort_first;
                o_grant[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_mdata = i_sdata;
    assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_wbcarbiter.sv
// Scoreboard bench for wbcarbiter: directed stimulus pushes expected responses and
// grant changes; negedge monitors pop and compare whenever the DUTs present them.
module tb_wbcarbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct {
        int         cyc;
        logic [3:0] mack;
        logic [3:0] merr;
        logic [31:0] mdata;
        int         own;
        bit         chk;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic       scyc;
    } grant_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_reset;
    logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0] i_maddr;
    logic [NM*DW-1:0] i_mdata;
    logic [NM*SW-1:0] i_msel;
    logic             i_sack, i_serr;
    logic [DW-1:0]    i_sdata;

    logic [NM-1:0] a_mack, a_merr, a_grant, z_mack, z_merr, z_grant;
    logic [DW-1:0] a_mdata, a_sdata, z_mdata, z_sdata;
    logic [AW-1:0] a_saddr, z_saddr;
    logic [SW-1:0] a_ssel, z_ssel;
    logic          a_scyc, a_sstb, a_swe, a_busy;
    logic          z_scyc, z_sstb, z_swe, z_busy;

    wbcarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(4), .TW(8)) dut_a (
        .i_clk(clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(a_mack), .o_mdata(a_mdata), .o_merr(a_merr),
        .o_scyc(a_scyc), .o_sstb(a_sstb), .o_swe(a_swe),
        .o_saddr(a_saddr), .o_sdata(a_sdata), .o_ssel(a_ssel),
        .i_sack(i_sack), .i_sdata(i_sdata), .i_serr(i_serr),
        .o_grant(a_grant), .o_busy(a_busy)
    );

    wbcarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(0), .TW(8)) dut_z (
        .i_clk(clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(z_mack), .o_mdata(z_mdata), .o_merr(z_merr),
        .o_scyc(z_scyc), .o_sstb(z_sstb), .o_swe(z_swe),
        .o_saddr(z_saddr), .o_sdata(z_sdata), .o_ssel(z_ssel),
        .i_sack(i_sack), .i_sdata(i_sdata), .i_serr(i_serr),
        .o_grant(z_grant), .o_busy(z_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int base;
    bit mon_en   = 1'b0;
    bit z_en     = 1'b0;

    resp_t  resp_q[$];
    grant_t grant_q[$];
    resp_t  zresp_q[$];
    resp_t  r_a, r_z;
    grant_t g_a;
    logic [3:0] prev_grant = '0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] exp_addr(input int m);
        return 32'h1000_0000 + 32'(m << 8);
    endfunction
    function automatic logic [31:0] exp_wdata(input int m);
        return 32'hD000_0000 + 32'(m);
    endfunction
    function automatic logic [3:0] exp_sel(input int m);
        return 4'(1 << m);
    endfunction
    function automatic logic exp_we(input int m);
        return m[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] c, input logic [3:0] s, input logic a, input logic e,
                       input logic [31:0] sd);
        i_mcyc  = c;
        i_mstb  = s;
        i_sack  = a;
        i_serr  = e;
        i_sdata = sd;
    endtask

    task automatic drv(input logic [3:0] c, input logic [3:0] s, input logic a, input logic e,
                       input logic [31:0] sd);
        set(c, s, a, e, sd);
        tick();
    endtask

    task automatic do_reset();
        set(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic exp_resp(input int c, input logic [3:0] mack, input logic [3:0] merr,
                            input logic [31:0] md, input int own, input bit chk);
        resp_t r;
        r.cyc = c; r.mack = mack; r.merr = merr; r.mdata = md; r.own = own; r.chk = chk;
        resp_q.push_back(r);
    endtask

    task automatic exp_grant(input int c, input logic [3:0] g, input logic sc);
        grant_t gr;
        gr.cyc = c; gr.grant = g; gr.scyc = sc;
        grant_q.push_back(gr);
    endtask

    task automatic exp_zresp(input int c, input logic [3:0] mack, input logic [31:0] md);
        resp_t r;
        r.cyc = c; r.mack = mack; r.merr = 4'b0000; r.mdata = md; r.own = 0; r.chk = 1'b0;
        zresp_q.push_back(r);
    endtask

    // Monitor for the TIMEOUT=4 instance: responses and grant changes.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_grant = a_grant;
        end else begin
            if ((a_mack | a_merr) !== 4'b0000) begin
                if (resp_q.size() == 0) begin
                    check("a_unexpected_resp", {a_mack, a_merr}, 8'h00);
                end else begin
                    r_a = resp_q.pop_front();
                    check("a_resp_cycle", 64'(cycle), 64'(r_a.cyc));
                    check("a_mack", a_mack, r_a.mack);
                    check("a_merr", a_merr, r_a.merr);
                    check("a_mdata", a_mdata, r_a.mdata);
                    if (r_a.chk) begin
                        check("a_saddr", a_saddr, exp_addr(r_a.own));
                        check("a_sdata", a_sdata, exp_wdata(r_a.own));
                        check("a_ssel", a_ssel, exp_sel(r_a.own));
                        check("a_swe", a_swe, exp_we(r_a.own));
                        check("a_scyc_sstb", {a_scyc, a_sstb}, 2'b11);
                    end
                end
            end
            if (a_grant !== prev_grant) begin
                if (grant_q.size() == 0) begin
                    check("a_unexpected_grant", a_grant, prev_grant);
                end else begin
                    g_a = grant_q.pop_front();
                    check("a_grant_cycle", 64'(cycle), 64'(g_a.cyc));
                    check("a_grant", a_grant, g_a.grant);
                    check("a_grant_scyc", a_scyc, g_a.scyc);
                    check("a_busy", a_busy, g_a.grant != 4'b0000);
                end
                prev_grant = a_grant;
            end
        end
    end

    // Monitor for the TIMEOUT=0 instance: responses only.
    always @(negedge clk) begin
        if (z_en && ((z_mack | z_merr) !== 4'b0000)) begin
            if (zresp_q.size() == 0) begin
                check("z_unexpected_resp", {z_mack, z_merr}, 8'h00);
            end else begin
                r_z = zresp_q.pop_front();
                check("z_resp_cycle", 64'(cycle), 64'(r_z.cyc));
                check("z_mack", z_mack, r_z.mack);
                check("z_merr", z_merr, r_z.merr);
                check("z_mdata", z_mdata, r_z.mdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        i_mwe = 4'b1010;
        for (int m = 0; m < NM; m++) begin
            i_maddr[m*AW +: AW] = exp_addr(m);
            i_mdata[m*DW +: DW] = exp_wdata(m);
            i_msel[m*SW +: SW]  = exp_sel(m);
        end
        i_reset = 1'b1;
        set(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h5A5A_A5A5);
        tick();
        tick();
        i_reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_grant", a_grant, 4'b0000);
        check("rst_ctl", {a_scyc, a_sstb, a_swe, a_busy}, 4'b0000);
        check("rst_resp", {a_mack, a_merr}, 8'h00);
        check("rst_bus", {a_saddr, a_sdata, a_ssel}, 68'h0);
        check("rst_mdata", a_mdata, 32'h5A5A_A5A5);
        mon_en = 1'b1;
        tick();

        // Single master 0 write, ack in the second strobe cycle.
        base = cycle;
        exp_grant(base + 1, 4'b0001, 1'b1);
        exp_resp(base + 2, 4'b0001, 4'b0000, 32'hCAFE_0001, 0, 1'b1);
        exp_grant(base + 4, 4'b0000, 1'b0);
        drv(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
        drv(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
        drv(4'b0001, 4'b0001, 1'b1, 1'b0, 32'hCAFE_0001);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Masters 0, 1, 3 requesting from reset: order 0 -> 1 -> 3 -> 0.
        do_reset();
        base = cycle;
        exp_grant(base + 1,  4'b0001, 1'b1);
        exp_resp (base + 1,  4'b0001, 4'b0000, 32'hA000_0001, 0, 1'b1);
        exp_grant(base + 3,  4'b0000, 1'b0);
        exp_grant(base + 4,  4'b0010, 1'b1);
        exp_resp (base + 4,  4'b0010, 4'b0000, 32'hA000_0004, 1, 1'b1);
        exp_grant(base + 6,  4'b0000, 1'b0);
        exp_grant(base + 7,  4'b1000, 1'b1);
        exp_resp (base + 7,  4'b1000, 4'b0000, 32'hA000_0007, 3, 1'b1);
        exp_grant(base + 9,  4'b0000, 1'b0);
        exp_grant(base + 10, 4'b0001, 1'b1);
        exp_resp (base + 10, 4'b0001, 4'b0000, 32'hA000_000A, 0, 1'b1);
        exp_grant(base + 12, 4'b0000, 1'b0);
        drv(4'b1011, 4'b1011, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b1, 1'b0, 32'hA000_0001);
        drv(4'b1010, 4'b1010, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b1, 1'b0, 32'hA000_0004);
        drv(4'b1001, 4'b1001, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b1, 1'b0, 32'hA000_0007);
        drv(4'b0011, 4'b0011, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b0, 1'b0, 32'h0);
        drv(4'b1011, 4'b1011, 1'b1, 1'b0, 32'hA000_000A);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Watchdog (TIMEOUT=4): owner 2 strobes, slave silent.
        base = cycle;
        exp_grant(base + 1, 4'b0100, 1'b1);
        exp_resp (base + 5, 4'b0000, 4'b0100, 32'h0000_0BAD, 2, 1'b0);
        exp_grant(base + 9, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) drv(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0000_0BAD);
        for (int k = 5; k < 8; k++) begin
            set(4'b0100, 4'b0100, k == 6, k == 7, 32'h0000_0BAD);
            @(negedge clk);
            check("abort_scyc_sstb", {a_scyc, a_sstb}, 2'b00);
            check("abort_grant", a_grant, 4'b0100);
            tick();
        end
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Same with an ack in the 4th strobe cycle: no error.
        base = cycle;
        exp_grant(base + 1, 4'b0100, 1'b1);
        exp_resp (base + 4, 4'b0100, 4'b0000, 32'h0000_0ACC, 2, 1'b1);
        exp_grant(base + 6, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) drv(4'b0100, 4'b0100, 1'b0, 1'b0, 32'h0);
        drv(4'b0100, 4'b0100, 1'b1, 1'b0, 32'h0000_0ACC);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Non-owner isolation: master 1 owns while master 0 holds cyc/stb.
        base = cycle;
        exp_grant(base + 1, 4'b0010, 1'b1);
        exp_resp (base + 2, 4'b0010, 4'b0000, 32'h0000_1111, 1, 1'b1);
        exp_grant(base + 4, 4'b0000, 1'b0);
        exp_grant(base + 5, 4'b0001, 1'b1);
        exp_resp (base + 5, 4'b0001, 4'b0000, 32'h0000_2222, 0, 1'b1);
        exp_grant(base + 7, 4'b0000, 1'b0);
        drv(4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0);
        drv(4'b0011, 4'b0011, 1'b0, 1'b0, 32'h0);
        drv(4'b0011, 4'b0011, 1'b1, 1'b0, 32'h0000_1111);
        drv(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
        drv(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0);
        drv(4'b0001, 4'b0001, 1'b1, 1'b0, 32'h0000_2222);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Reset while master 1 is BUSY with stb high; then masters 0 and 2 request.
        base = cycle;
        exp_grant(base + 1, 4'b0010, 1'b1);
        exp_grant(base + 2, 4'b0000, 1'b0);
        exp_grant(base + 3, 4'b0001, 1'b1);
        exp_resp (base + 3, 4'b0001, 4'b0000, 32'h0000_3333, 0, 1'b1);
        exp_grant(base + 5, 4'b0000, 1'b0);
        drv(4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0);
        i_reset = 1'b1;
        drv(4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0);
        i_reset = 1'b0;
        set(4'b0101, 4'b0101, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("post_reset_scyc", a_scyc, 1'b0);
        check("post_reset_resp", {a_mack, a_merr}, 8'h00);
        tick();
        drv(4'b0101, 4'b0101, 1'b1, 1'b0, 32'h0000_3333);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        // TIMEOUT=0 instance: 1000-cycle stall, no error; TIMEOUT=4 instance aborts.
        do_reset();
        z_en = 1'b1;
        base = cycle;
        exp_grant(base + 1, 4'b0001, 1'b1);
        exp_resp (base + 5, 4'b0000, 4'b0001, 32'h0000_0BAD, 0, 1'b0);
        exp_grant(base + 1003, 4'b0000, 1'b0);
        exp_zresp(base + 1001, 4'b0001, 32'h600D_0000);
        drv(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0000_0BAD);
        for (int k = 1; k <= 1000; k++) begin
            set(4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0000_0BAD);
            if (k == 1000) begin
                @(negedge clk);
                check("z_busy_stall", {z_busy, z_scyc, z_grant}, 6'b11_0001);
            end
            tick();
        end
        drv(4'b0001, 4'b0001, 1'b1, 1'b0, 32'h600D_0000);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        drv(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        check("z_idle_end", z_busy, 1'b0);
        check("resp_q_drained", 64'(resp_q.size()), 64'd0);
        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("zresp_q_drained", 64'(zresp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
